// File: rtl/rast_params.sv
`default_nettype none
// ============================================================================
// Module      : rast_params (package)
// Description : Shared rasterizer word-format defaults and fragment record.
// Revision    : 1.0 - initial release
// ============================================================================
package rast_params;

    localparam int SIGFIG      = 24;
    localparam int RADIX       = 10;
    localparam int AXIS        = 3;
    localparam int COLORS      = 3;
    localparam int NUM_SAMPLES = 4;

    typedef struct packed {
        logic [AXIS-1:0][SIGFIG-1:0]   location;
        logic [COLORS-1:0][SIGFIG-1:0] color;
    } frag_t;

endpackage
`default_nettype wire

// File: rtl/frag_fifo_mw.sv
`default_nettype none
// ============================================================================
// Module      : frag_fifo_mw
// Description : Multi-write, single-read FIFO; each lane writes at wr_ptr+off.
// Revision    : 1.0 - initial release
// ============================================================================
module frag_fifo_mw #(
    parameter int WIDTH = 144,
    parameter int DEPTH = 32,
    parameter int LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0]          wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_off [LANES],
    input  logic [WIDTH-1:0]          wr_data [LANES],
    input  logic [$clog2(DEPTH):0]    wr_num,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int c_pw = $clog2(DEPTH);
    localparam int c_cw = c_pw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;

    // Lane offsets are distinct, so the parallel writes never collide.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (wr_en[l]) begin
                r_mem[r_wr_ptr + wr_off[l]] <= wr_data[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_pw'(wr_num);
            r_rd_ptr <= r_rd_ptr + c_pw'(rd_en);
            r_count  <= r_count + wr_num - c_cw'(rd_en);
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/hit_collect.sv
`default_nettype none
// ============================================================================
// Module      : hit_collect
// Description : Packs per-lane rasterizer hits into a fragment FIFO, all-or-none.
// Revision    : 1.0 - initial release
// ============================================================================
module hit_collect
    import rast_params::*;
#(
    parameter int SIGFIG      = rast_params::SIGFIG,
    parameter int RADIX       = rast_params::RADIX,
    parameter int AXIS        = rast_params::AXIS,
    parameter int COLORS      = rast_params::COLORS,
    parameter int NUM_SAMPLES = rast_params::NUM_SAMPLES,
    parameter int DEPTH       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] hit_R18S [NUM_SAMPLES][AXIS],
    input  logic [SIGFIG-1:0]        color_R18U [COLORS],
    input  logic [NUM_SAMPLES-1:0]   hit_valid_R18H,
    output logic                     frag_valid,
    input  logic                     frag_ready,
    output logic signed [SIGFIG-1:0] frag_S [AXIS],
    output logic [SIGFIG-1:0]        frag_color_U [COLORS],
    output logic                     almost_full,
    output logic                     overflow,
    output logic [31:0]              hit_count,
    output logic [31:0]              drop_count
);

    localparam int          c_pw  = $clog2(DEPTH);
    localparam int          c_cw  = c_pw + 1;
    localparam int          c_w   = SIGFIG * (AXIS + COLORS);
    localparam logic [31:0] c_max = 32'hFFFF_FFFF;

    logic [c_cw-1:0]        w_n;
    logic [c_cw-1:0]        w_free;
    logic [c_cw-1:0]        w_count;
    logic [c_cw-1:0]        w_wr_num;
    logic [c_pw-1:0]        w_off   [NUM_SAMPLES];
    logic [c_w-1:0]         w_entry [NUM_SAMPLES];
    logic [c_w-1:0]         w_head;
    logic [NUM_SAMPLES-1:0] w_wr_en;
    logic                   w_pop;
    logic                   w_accept;
    logic                   w_drop;
    logic [31:0]            w_unused_radix;

    logic                   r_overflow;
    logic [31:0]            r_hit_count;
    logic [31:0]            r_drop_count;

    // Fraction position is carried through untouched.
    assign w_unused_radix = 32'(RADIX);

    // Each valid lane's slot is the number of valid lanes below it.
    always_comb begin
        w_n = '0;
        for (int l = 0; l < NUM_SAMPLES; l++) begin
            w_off[l] = c_pw'(w_n);
            w_n      = w_n + c_cw'(hit_valid_R18H[l]);
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_SAMPLES; l++) begin
            w_entry[l] = '0;
            for (int a = 0; a < AXIS; a++) begin
                w_entry[l][a*SIGFIG +: SIGFIG] = hit_R18S[l][a];
            end
            for (int c = 0; c < COLORS; c++) begin
                w_entry[l][(AXIS+c)*SIGFIG +: SIGFIG] = color_R18U[c];
            end
        end
    end

    assign frag_valid  = (w_count != '0);
    assign w_pop       = frag_valid & frag_ready;
    // A same-cycle pop makes room before the push is judged.
    assign w_free      = c_cw'(DEPTH) - w_count + c_cw'(w_pop);
    assign w_accept    = (w_n != '0) && (w_n <= w_free);
    assign w_drop      = (w_n > w_free);
    assign w_wr_en     = hit_valid_R18H & {NUM_SAMPLES{w_accept}};
    assign w_wr_num    = w_accept ? w_n : '0;
    assign almost_full = (c_cw'(DEPTH) - w_count) < c_cw'(2 * NUM_SAMPLES);

    frag_fifo_mw #(
        .WIDTH (c_w),
        .DEPTH (DEPTH),
        .LANES (NUM_SAMPLES)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_off  (w_off),
        .wr_data (w_entry),
        .wr_num  (w_wr_num),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .count   (w_count)
    );

    always_comb begin
        for (int a = 0; a < AXIS; a++) begin
            frag_S[a] = w_head[a*SIGFIG +: SIGFIG];
        end
        for (int c = 0; c < COLORS; c++) begin
            frag_color_U[c] = w_head[(AXIS+c)*SIGFIG +: SIGFIG];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_hit_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_accept) begin
                r_hit_count <= (r_hit_count > c_max - 32'(w_n)) ? c_max
                                                                : r_hit_count + 32'(w_n);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != c_max) begin
                    r_drop_count <= r_drop_count + 32'd1;
                end
            end
        end
    end

    assign overflow   = r_overflow;
    assign hit_count  = r_hit_count;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: doc/hit_collect.md
HIT_COLLECT -- requirements
Module: hit_collect

Interface
REQ-001 Parameter SIGFIG, default 24, bits per coordinate/color word.
REQ-002 Parameter RADIX, default 10, fraction bits (pass-through only, no arithmetic).
REQ-003 Parameter AXIS, default 3, coordinates per hit (x,y,z).
REQ-004 Parameter COLORS, default 3, color channels.
REQ-005 Parameter NUM_SAMPLES, default 4, hit lanes per input cycle.
REQ-006 Parameter DEPTH, default 32, FIFO entries, power of two, at least 2*NUM_SAMPLES.
REQ-007 clk  input  1  single clock, all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 hit_R18S  input  signed [SIGFIG-1:0] [NUM_SAMPLES][AXIS]  per-lane sample location from rast.
REQ-010 color_R18U  input  unsigned [SIGFIG-1:0] [COLORS]  triangle color shared by all lanes this cycle.
REQ-011 hit_valid_R18H  input  1 [NUM_SAMPLES]  per-lane hit flag.
REQ-012 frag_valid  output  1  output fragment present.
REQ-013 frag_ready  input  1  consumer accepts fragment.
REQ-014 frag_S  output  signed [SIGFIG-1:0] [AXIS]  fragment location.
REQ-015 frag_color_U  output  unsigned [SIGFIG-1:0] [COLORS]  fragment color.
REQ-016 almost_full  output  1  free entries < 2*NUM_SAMPLES.
REQ-017 overflow  output  1  sticky, set on any dropped input cycle.
REQ-018 hit_count  output  32  fragments accepted into FIFO.
REQ-019 drop_count  output  32  input cycles dropped.

Function
REQ-020 Input has no backpressure; every cycle is sampled, N = popcount(hit_valid_R18H).
REQ-021 If N <= free entries, all N hits SHALL be written in one cycle, lane 0 first, packed contiguously from write pointer; each entry = {hit_R18S[lane], color_R18U}.
REQ-022 If N > free entries, the whole cycle SHALL be dropped (no partial write), overflow set, drop_count +1.
REQ-023 free entries SHALL be computed after counting a pop occurring the same cycle (pop and push simultaneous, pop frees space first).
REQ-024 N = 0 SHALL change no state.
REQ-025 Pop SHALL occur when frag_valid && frag_ready; one entry per cycle, FIFO order.
REQ-026 Latency: hit written in cycle T SHALL appear on frag_S no earlier than T+1 (registered read, no combinational bypass).
REQ-027 frag_S/frag_color_U SHALL hold stable while frag_valid && !frag_ready.
REQ-028 frag_valid SHALL equal (occupancy != 0).
REQ-029 Pointers SHALL wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1 distinguishes full from empty.
REQ-030 hit_count SHALL add N per accepted cycle; both counters saturate at 2^32-1.
REQ-031 overflow SHALL remain set until reset.

Reset
REQ-032 On rst: pointers, occupancy, counters = 0; frag_valid = 0; almost_full = 0; overflow = 0.
REQ-033 Reset mid-operation SHALL discard all stored entries and any same-cycle input.
REQ-034 FIFO storage array SHALL not require reset.

Structure
REQ-035 SIGFIG, RADIX, AXIS, COLORS, NUM_SAMPLES defaults and a frag_t struct {location, color} SHALL live in the shared rast_params package.
REQ-036 Storage SHALL be one sub-module frag_fifo_mw (multi-write, single-read), with lane packing and counters in hit_collect.

Verification
REQ-037 Reset, then hit_valid=1011, frag_ready=1 -> frag_valid rises next cycle; lanes 0,1,3 emerge in order on 3 consecutive cycles; hit_count=3.
REQ-038 frag_ready=0, push 8 cycles of 1111 with DEPTH=32 -> occupancy 32, almost_full=1, overflow=0; 9th push 0001 -> dropped, overflow=1, drop_count=1, hit_count=32.
REQ-039 FIFO full, same cycle frag_ready=1 and hit_valid=0001 -> push accepted, occupancy stays 32.
REQ-040 frag_ready toggled randomly over 1000 cycles of random lanes, scoreboard -> output sequence matches accepted input sequence exactly, wrap crossed at least 10 times.
REQ-041 Occupancy 10, assert rst one cycle with hit_valid=1111 -> next cycle frag_valid=0, hit_count=0, occupancy 0.
